// File: rtl/ex_stage_pkg.sv
// Shared constants, opcode encodings and the EX/MEM register layout for the execute stage.
package ex_stage_pkg;

    localparam int CPU_WIDTH  = 16;
    localparam int MUL_CYCLES = 16;

    localparam int HOLD_W  = 2;
    localparam int CLEAR_W = 2;

    // Only the PPL and MEM variants reach into EX; the PC/IF variants act upstream only.
    localparam logic [HOLD_W-1:0]  HOLD_NONE  = 2'b00;
    localparam logic [HOLD_W-1:0]  HOLD_PC    = 2'b01;
    localparam logic [HOLD_W-1:0]  HOLD_PPL   = 2'b10;
    localparam logic [HOLD_W-1:0]  HOLD_MEM   = 2'b11;
    localparam logic [CLEAR_W-1:0] CLEAR_NONE = 2'b00;
    localparam logic [CLEAR_W-1:0] CLEAR_IF   = 2'b01;
    localparam logic [CLEAR_W-1:0] CLEAR_PPL  = 2'b10;
    localparam logic [CLEAR_W-1:0] CLEAR_MEM  = 2'b11;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR  = 3'b011,
        ALU_XOR = 3'b100, ALU_SLL = 3'b101, ALU_SRL = 3'b110, ALU_MUL_SRA = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        CMP_NONE = 2'b00, CMP_EQ = 2'b01, CMP_LTS = 2'b10, CMP_LTU = 2'b11
    } cmp_op_t;

    typedef enum logic [1:0] {
        JMP_NONE = 2'b00, JMP_JUMP = 2'b01, JMP_BRANCH = 2'b10, JMP_NONE2 = 2'b11
    } jump_op_t;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00, MUL_BUSY = 2'b01, MUL_DONE = 2'b10
    } mul_state_t;

    typedef struct packed {
        logic [2:0]           rd;
        logic [CPU_WIDTH-1:0] alu_res;
        logic [CPU_WIDTH-1:0] wdata;
        logic                 reg_we;
        logic                 rw_sel;
        logic                 mem_ctrl;
        logic                 mem_we;
    } ex_mem_t;

    function automatic logic is_hold(input logic [HOLD_W-1:0] f);
        return (f == HOLD_PPL) || (f == HOLD_MEM);
    endfunction

    function automatic logic is_clear(input logic [CLEAR_W-1:0] f);
        return (f == CLEAR_PPL) || (f == CLEAR_MEM);
    endfunction

endpackage

// File: rtl/ex_stage_mul.sv
// Iterative shift-add multiplier (low W bits of the product) with IDLE/BUSY/DONE control.
module ex_mul
    import ex_stage_pkg::*;
#(
    parameter int W = CPU_WIDTH,
    parameter int N = MUL_CYCLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic         freeze,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] product
);

    localparam int CW = $clog2(N);

    mul_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic          launch;

    // rst gates the launch so the stall drops the instant reset is asserted.
    assign launch  = (state_q == MUL_IDLE) && start && !abort && !freeze && !rst;
    assign busy    = (state_q == MUL_BUSY) || launch;
    assign done    = (state_q == MUL_DONE);
    assign product = acc_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        if (abort) begin
            state_d = MUL_IDLE;
            cnt_d   = '0;
        end else if (!freeze) begin
            case (state_q)
                MUL_IDLE: begin
                    if (launch) begin
                        state_d = MUL_BUSY;
                        a_d     = a;
                        b_d     = b;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end
                end
                MUL_BUSY: begin
                    if (b_q[0]) acc_d = acc_q + a_q;
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(N - 1)) state_d = MUL_DONE;
                end
                default: state_d = MUL_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MUL_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, compare, jump redirect, CSR write, EX/MEM register.
// Optional EX_MUL_EN: ALUop 111 becomes a multi-cycle MUL (ex_mul) instead of SRA.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [HOLD_W-1:0]    hold_flag,
    input  logic [CLEAR_W-1:0]   clear_flag,
    input  logic [2:0]           EX_rd,
    input  logic [CPU_WIDTH-1:0] EX_RD,
    input  logic [CPU_WIDTH-1:0] EX_RS,
    input  logic [CPU_WIDTH-1:0] EX_IMM,
    input  logic [CPU_WIDTH-1:0] EX_inst_addr,
    input  logic                 EX_CSR_wr,
    input  logic [1:0]           EX_JUMPop,
    input  logic                 EX_IMMop,
    input  logic [2:0]           EX_ALUop,
    input  logic [1:0]           EX_CMPop,
    input  logic                 EX_RegWe,
    input  logic                 EX_RWSel,
    input  logic                 EX_mem_ctrl,
    input  logic                 EX_ABSel,
    input  logic                 EX_IMMSel,
    output logic                 jump_flag,
    output logic [CPU_WIDTH-1:0] jump_addr,
    output logic                 clear_req,
    output logic                 hold_req,
    output logic                 csr_we,
    output logic [3:0]           csr_waddr,
    output logic [CPU_WIDTH-1:0] csr_wdata,
    output logic [2:0]           MEM_rd,
    output logic [CPU_WIDTH-1:0] MEM_ALUres,
    output logic [CPU_WIDTH-1:0] MEM_wdata,
    output logic                 MEM_RegWe,
    output logic                 MEM_RWSel,
    output logic                 MEM_mem_ctrl,
    output logic                 MEM_mem_we
);

    localparam int W = CPU_WIDTH;

    logic         hold_act, clear_act, gate, jump_op, cmp_t;
    logic [W-1:0] imm_val, op_a, op_b, alu_res;
    ex_mem_t      ex_mem_q, ex_mem_d;

    assign hold_act  = is_hold(hold_flag);
    assign clear_act = is_clear(clear_flag);
    assign gate      = hold_act || clear_act;

    assign imm_val = EX_IMMop ? {EX_IMM[7:0], 8'h00} : EX_IMM;
    assign op_a    = EX_ABSel ? EX_inst_addr : EX_RD;
    assign op_b    = EX_IMMSel ? imm_val : EX_RS;

`ifdef EX_MUL_EN
    logic         mul_start, mul_busy, mul_done;
    logic [W-1:0] mul_product;

    // A decoded jump takes precedence; the MUL is simply never launched.
    assign mul_start = (EX_ALUop == ALU_MUL_SRA) && !jump_op;

    ex_mul #(.W(W), .N(MUL_CYCLES)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .abort   (clear_act),
        .freeze  (hold_act),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );
    assign hold_req = mul_busy;
`else
    assign hold_req = 1'b0;
`endif

    always_comb begin
        alu_res = '0;
        case (EX_ALUop)
            ALU_ADD: alu_res = op_a + op_b;
            ALU_SUB: alu_res = op_a - op_b;
            ALU_AND: alu_res = op_a & op_b;
            ALU_OR:  alu_res = op_a | op_b;
            ALU_XOR: alu_res = op_a ^ op_b;
            ALU_SLL: alu_res = op_a << op_b[3:0];
            ALU_SRL: alu_res = op_a >> op_b[3:0];
`ifdef EX_MUL_EN
            ALU_MUL_SRA: alu_res = mul_done ? mul_product : '0;
`else
            ALU_MUL_SRA: alu_res = $unsigned($signed(op_a) >>> op_b[3:0]);
`endif
            default: alu_res = '0;
        endcase
    end

    // Branch compares the register operands, independent of the ALU operand muxes.
    always_comb begin
        cmp_t = 1'b0;
        case (EX_CMPop)
            CMP_EQ:  cmp_t = (EX_RD == EX_RS);
            CMP_LTS: cmp_t = ($signed(EX_RD) < $signed(EX_RS));
            CMP_LTU: cmp_t = (EX_RD < EX_RS);
            default: cmp_t = 1'b0;
        endcase
    end

    assign jump_op   = (EX_JUMPop == JMP_JUMP) || (EX_JUMPop == JMP_BRANCH);
    assign jump_flag = jump_op && ((EX_JUMPop == JMP_JUMP) || cmp_t) && !gate;
    assign jump_addr = gate ? '0 :
                       (EX_JUMPop == JMP_JUMP) ? alu_res : (EX_inst_addr + imm_val);
    assign clear_req = jump_flag;

    assign csr_we    = EX_CSR_wr && !hold_req && !gate;
    assign csr_waddr = gate ? 4'h0 : EX_IMM[3:0];
    assign csr_wdata = gate ? '0 : op_a;

    always_comb begin
        ex_mem_d = ex_mem_q;
        if (clear_act) begin
            ex_mem_d = '0;
        end else if (hold_act) begin
            ex_mem_d = ex_mem_q;
        end else if (hold_req) begin
            ex_mem_d = '0;
        end else begin
            ex_mem_d.rd       = EX_rd;
            ex_mem_d.alu_res  = alu_res;
            ex_mem_d.wdata    = EX_RS;
            ex_mem_d.reg_we   = EX_RegWe;
            ex_mem_d.rw_sel   = EX_RWSel;
            ex_mem_d.mem_ctrl = EX_mem_ctrl;
            ex_mem_d.mem_we   = EX_mem_ctrl && !EX_RegWe;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ex_mem_q <= '0;
        else     ex_mem_q <= ex_mem_d;
    end

    assign MEM_rd       = ex_mem_q.rd;
    assign MEM_ALUres   = ex_mem_q.alu_res;
    assign MEM_wdata    = ex_mem_q.wdata;
    assign MEM_RegWe    = ex_mem_q.reg_we;
    assign MEM_RWSel    = ex_mem_q.rw_sel;
    assign MEM_mem_ctrl = ex_mem_q.mem_ctrl;
    assign MEM_mem_we   = ex_mem_q.mem_we;

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage; MUL scenarios run when EX_MUL_EN is defined, SRA otherwise.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic [HOLD_W-1:0]  hold_flag;
    logic [CLEAR_W-1:0] clear_flag;
    logic [2:0]  EX_rd;
    logic [15:0] EX_RD, EX_RS, EX_IMM, EX_inst_addr;
    logic        EX_CSR_wr, EX_IMMop, EX_RegWe, EX_RWSel, EX_mem_ctrl, EX_ABSel, EX_IMMSel;
    logic [1:0]  EX_JUMPop, EX_CMPop;
    logic [2:0]  EX_ALUop;
    logic        jump_flag, clear_req, hold_req, csr_we;
    logic [15:0] jump_addr, csr_wdata, MEM_ALUres, MEM_wdata;
    logic [3:0]  csr_waddr;
    logic [2:0]  MEM_rd;
    logic        MEM_RegWe, MEM_RWSel, MEM_mem_ctrl, MEM_mem_we;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst(rst), .hold_flag(hold_flag), .clear_flag(clear_flag),
        .EX_rd(EX_rd), .EX_RD(EX_RD), .EX_RS(EX_RS), .EX_IMM(EX_IMM),
        .EX_inst_addr(EX_inst_addr), .EX_CSR_wr(EX_CSR_wr), .EX_JUMPop(EX_JUMPop),
        .EX_IMMop(EX_IMMop), .EX_ALUop(EX_ALUop), .EX_CMPop(EX_CMPop),
        .EX_RegWe(EX_RegWe), .EX_RWSel(EX_RWSel), .EX_mem_ctrl(EX_mem_ctrl),
        .EX_ABSel(EX_ABSel), .EX_IMMSel(EX_IMMSel),
        .jump_flag(jump_flag), .jump_addr(jump_addr), .clear_req(clear_req),
        .hold_req(hold_req), .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .MEM_rd(MEM_rd), .MEM_ALUres(MEM_ALUres), .MEM_wdata(MEM_wdata),
        .MEM_RegWe(MEM_RegWe), .MEM_RWSel(MEM_RWSel), .MEM_mem_ctrl(MEM_mem_ctrl),
        .MEM_mem_we(MEM_mem_we)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        hold_flag = HOLD_NONE; clear_flag = CLEAR_NONE;
        EX_rd = 3'd0; EX_RD = 16'h0; EX_RS = 16'h0; EX_IMM = 16'h0; EX_inst_addr = 16'h0;
        EX_CSR_wr = 1'b0; EX_JUMPop = 2'b00; EX_IMMop = 1'b0; EX_ALUop = 3'b000;
        EX_CMPop = 2'b00; EX_RegWe = 1'b0; EX_RWSel = 1'b0; EX_mem_ctrl = 1'b0;
        EX_ABSel = 1'b0; EX_IMMSel = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_nop();
        step(); step();
        n_cmp++; if (MEM_ALUres !== 16'h0) begin n_bad++; $display("FAIL reset_alures: got %h want 0000", MEM_ALUres); end
        n_cmp++; if ({MEM_RegWe, MEM_RWSel, MEM_mem_ctrl, MEM_mem_we, MEM_rd} !== 7'b0) begin n_bad++; $display("FAIL reset_ctrl: got %b want 0", {MEM_RegWe, MEM_RWSel, MEM_mem_ctrl, MEM_mem_we, MEM_rd}); end
        n_cmp++; if (hold_req !== 1'b0) begin n_bad++; $display("FAIL reset_hold_req: got %b want 0", hold_req); end
        rst = 1'b0;
        step();
        $display("reset: MEM_ALUres=%h hold_req=%b", MEM_ALUres, hold_req);
    endtask

    task automatic test_add();
        set_nop();
        EX_RD = 16'h7FFF; EX_RS = 16'h0001; EX_RegWe = 1'b1; EX_rd = 3'd3;
        EX_CSR_wr = 1'b1; EX_IMM = 16'h0005;
        #1;
        n_cmp++; if ({csr_we, csr_waddr, csr_wdata} !== {1'b1, 4'h5, 16'h7FFF}) begin n_bad++; $display("FAIL csr_write: got %b/%h/%h want 1/5/7fff", csr_we, csr_waddr, csr_wdata); end
        step();
        n_cmp++; if (MEM_ALUres !== 16'h8000) begin n_bad++; $display("FAIL add_res: got %h want 8000", MEM_ALUres); end
        n_cmp++; if ({MEM_RegWe, MEM_rd, MEM_wdata} !== {1'b1, 3'd3, 16'h0001}) begin n_bad++; $display("FAIL add_ctrl: got %b/%0d/%h want 1/3/0001", MEM_RegWe, MEM_rd, MEM_wdata); end
        $display("add: MEM_ALUres=%h", MEM_ALUres);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [15:0] rd, rs, imm;
        logic        immsel, absel, immop;
        logic [15:0] exp;
    } vec_t;

    task automatic test_alu_ops();
        vec_t v[10];
        v = '{
            '{3'b001, 16'h0005, 16'h0007, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hFFFE},
            '{3'b010, 16'hF0F0, 16'h3C3C, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h3030},
            '{3'b011, 16'hF000, 16'h000F, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hF00F},
            '{3'b100, 16'hFFFF, 16'h0F0F, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hF0F0},
            '{3'b101, 16'h0F0F, 16'h0000, 16'h0004, 1'b1, 1'b0, 1'b0, 16'hF0F0},
            '{3'b110, 16'h8000, 16'h000F, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0001},
            '{3'b110, 16'h8000, 16'h0013, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h1000},
            '{3'b000, 16'h0001, 16'h0000, 16'h3412, 1'b1, 1'b0, 1'b1, 16'h1201},
            '{3'b000, 16'hAAAA, 16'h0000, 16'h0004, 1'b1, 1'b1, 1'b0, 16'h0104},
            '{3'b001, 16'h0000, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hFFFF}
        };
        for (int i = 0; i < 10; i++) begin
            set_nop();
            EX_ALUop = v[i].op; EX_RD = v[i].rd; EX_RS = v[i].rs; EX_IMM = v[i].imm;
            EX_IMMSel = v[i].immsel; EX_ABSel = v[i].absel; EX_IMMop = v[i].immop;
            EX_inst_addr = 16'h0100; EX_RegWe = 1'b1; EX_rd = 3'(i);
            step();
            n_cmp++; if (MEM_ALUres !== v[i].exp) begin n_bad++; $display("FAIL alu_vec%0d: got %h want %h", i, MEM_ALUres, v[i].exp); end
            $display("alu vec%0d op=%b res=%h", i, v[i].op, MEM_ALUres);
        end
        set_nop();
        EX_mem_ctrl = 1'b1; EX_RS = 16'hBEEF;
        step();
        n_cmp++; if ({MEM_mem_ctrl, MEM_mem_we, MEM_RegWe, MEM_wdata} !== {3'b110, 16'hBEEF}) begin n_bad++; $display("FAIL store_ctrl: got %b%b%b/%h want 110/beef", MEM_mem_ctrl, MEM_mem_we, MEM_RegWe, MEM_wdata); end
        EX_RegWe = 1'b1; EX_RWSel = 1'b1;
        step();
        n_cmp++; if ({MEM_mem_ctrl, MEM_mem_we, MEM_RegWe, MEM_RWSel} !== 4'b1011) begin n_bad++; $display("FAIL load_ctrl: got %b%b%b%b want 1011", MEM_mem_ctrl, MEM_mem_we, MEM_RegWe, MEM_RWSel); end
        $display("store/load: mem_we=%b rwsel=%b", MEM_mem_we, MEM_RWSel);
    endtask

    task automatic test_branch();
        set_nop();
        EX_CMPop = 2'b01; EX_RD = 16'd5; EX_RS = 16'd5; EX_inst_addr = 16'h0040;
        EX_IMM = 16'h0010; EX_JUMPop = 2'b10;
        #1;
        n_cmp++; if ({jump_flag, jump_addr, clear_req} !== {1'b1, 16'h0050, 1'b1}) begin n_bad++; $display("FAIL beq_taken: got %b/%h/%b want 1/0050/1", jump_flag, jump_addr, clear_req); end
        EX_RS = 16'd6; #1;
        n_cmp++; if ({jump_flag, clear_req} !== 2'b00) begin n_bad++; $display("FAIL beq_not_taken: got %b%b want 00", jump_flag, clear_req); end
        EX_RD = 16'hFFFF; EX_RS = 16'h0001; EX_CMPop = 2'b10; #1;
        n_cmp++; if (jump_flag !== 1'b1) begin n_bad++; $display("FAIL blt_signed: got %b want 1", jump_flag); end
        EX_CMPop = 2'b11; #1;
        n_cmp++; if (jump_flag !== 1'b0) begin n_bad++; $display("FAIL blt_unsigned: got %b want 0", jump_flag); end
        set_nop();
        EX_JUMPop = 2'b01; EX_RD = 16'h0200; EX_IMMSel = 1'b1; EX_IMM = 16'h0008; #1;
        n_cmp++; if ({jump_flag, jump_addr} !== {1'b1, 16'h0208}) begin n_bad++; $display("FAIL jump: got %b/%h want 1/0208", jump_flag, jump_addr); end
        EX_CSR_wr = 1'b1; hold_flag = HOLD_PPL; #1;
        n_cmp++; if ({jump_flag, jump_addr, csr_we} !== 18'b0) begin n_bad++; $display("FAIL jump_hold_gate: got %b/%h/%b want 0/0000/0", jump_flag, jump_addr, csr_we); end
        hold_flag = HOLD_NONE; clear_flag = CLEAR_MEM; #1;
        n_cmp++; if ({jump_flag, clear_req, csr_we} !== 3'b0) begin n_bad++; $display("FAIL jump_clear_gate: got %b%b%b want 000", jump_flag, clear_req, csr_we); end
        $display("branch: done");
        set_nop();
        step();
    endtask

    task automatic test_hold_clear();
        set_nop();
        EX_RD = 16'h1111; EX_RS = 16'h2222; EX_RegWe = 1'b1;
        step();
        EX_RD = 16'h0001; EX_RS = 16'h0001; hold_flag = HOLD_MEM;
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++; if (MEM_ALUres !== 16'h3333) begin n_bad++; $display("FAIL hold_keep%0d: got %h want 3333", c, MEM_ALUres); end
            $display("hold cycle %0d: MEM_ALUres=%h", c, MEM_ALUres);
        end
        hold_flag = HOLD_PC;
        step();
        n_cmp++; if (MEM_ALUres !== 16'h0002) begin n_bad++; $display("FAIL hold_pc_capture: got %h want 0002", MEM_ALUres); end
        hold_flag = HOLD_NONE; clear_flag = CLEAR_PPL; EX_RD = 16'h0005;
        step();
        n_cmp++; if ({MEM_ALUres, MEM_RegWe} !== 17'h0) begin n_bad++; $display("FAIL clear_bubble: got %h/%b want 0000/0", MEM_ALUres, MEM_RegWe); end
        clear_flag = CLEAR_IF;
        step();
        n_cmp++; if (MEM_ALUres !== 16'h0006) begin n_bad++; $display("FAIL clear_if_capture: got %h want 0006", MEM_ALUres); end
        $display("clear: MEM_ALUres=%h", MEM_ALUres);
    endtask

    task automatic test_async_reset();
        set_nop();
        EX_RD = 16'h1234; EX_RegWe = 1'b1;
        step();
        #3 rst = 1'b1;
        #1;
        n_cmp++; if ({MEM_ALUres, MEM_RegWe} !== 17'h0) begin n_bad++; $display("FAIL async_reset: got %h/%b want 0000/0", MEM_ALUres, MEM_RegWe); end
        step();
        rst = 1'b0;
        step();
        $display("async reset: MEM_ALUres=%h", MEM_ALUres);
    endtask

`ifdef EX_MUL_EN
    task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input int hold_from,
                           input int hold_len, input int exp_hi, input logic [15:0] exp_p);
        int  hi;
        logic leak;
        hi = 0; leak = 1'b0;
        set_nop();
        EX_RD = a; EX_RS = b; EX_ALUop = 3'b111; EX_RegWe = 1'b1; EX_rd = 3'd5;
        for (int c = 0; c < 60; c++) begin
            hold_flag = (c >= hold_from && c < hold_from + hold_len) ? HOLD_MEM : HOLD_NONE;
            #1;
            if (hold_req !== 1'b1) break;
            hi++;
            if (c > 0 && MEM_RegWe !== 1'b0) leak = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++; if (hi != exp_hi) begin n_bad++; $display("FAIL mul_hold_cycles: got %0d want %0d", hi, exp_hi); end
        n_cmp++; if (leak !== 1'b0) begin n_bad++; $display("FAIL mul_bubbles: got leak=%b want 0", leak); end
        step();
        set_nop();
        #1;
        n_cmp++; if ({MEM_ALUres, MEM_RegWe, MEM_rd} !== {exp_p, 1'b1, 3'd5}) begin n_bad++; $display("FAIL mul_result: got %h/%b/%0d want %h/1/5", MEM_ALUres, MEM_RegWe, MEM_rd, exp_p); end
        n_cmp++; if (hold_req !== 1'b0) begin n_bad++; $display("FAIL mul_idle_after: got %b want 0", hold_req); end
        $display("mul %h*%h: hold cycles=%0d res=%h", a, b, hi, MEM_ALUres);
    endtask

    task automatic test_mul();
        run_mul(16'd300, 16'd200, -1, 0, 17, 16'hEA60);
        run_mul(16'hFFFF, 16'hFFFF, -1, 0, 17, 16'h0001);
        run_mul(16'd300, 16'd200, 4, 3, 20, 16'hEA60);
    endtask

    task automatic test_mul_abort();
        set_nop();
        EX_RD = 16'd300; EX_RS = 16'd200; EX_ALUop = 3'b111; EX_RegWe = 1'b1;
        #1;
        n_cmp++; if (hold_req !== 1'b1) begin n_bad++; $display("FAIL abort_issue_hold: got %b want 1", hold_req); end
        for (int c = 0; c < 5; c++) step();
        clear_flag = CLEAR_PPL; EX_ALUop = 3'b000;
        step();
        set_nop();
        #1;
        n_cmp++; if ({hold_req, MEM_ALUres, MEM_RegWe} !== 18'h0) begin n_bad++; $display("FAIL abort_bubble: got %b/%h/%b want 0/0000/0", hold_req, MEM_ALUres, MEM_RegWe); end
        step();
        n_cmp++; if (hold_req !== 1'b0) begin n_bad++; $display("FAIL abort_idle: got %b want 0", hold_req); end
        $display("mul abort: hold_req=%b", hold_req);
        EX_JUMPop = 2'b01; EX_ALUop = 3'b111; #1;
        n_cmp++; if ({jump_flag, hold_req} !== 2'b10) begin n_bad++; $display("FAIL jump_over_mul: got %b%b want 10", jump_flag, hold_req); end
        set_nop();
        step();
    endtask

    task automatic test_mul_reset();
        set_nop();
        EX_RD = 16'd300; EX_RS = 16'd200; EX_ALUop = 3'b111;
        step(); step(); step();
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({hold_req, MEM_ALUres, MEM_RegWe} !== 18'h0) begin n_bad++; $display("FAIL mul_async_reset: got %b/%h/%b want 0/0000/0", hold_req, MEM_ALUres, MEM_RegWe); end
        set_nop();
        step();
        rst = 1'b0;
        step();
        n_cmp++; if (hold_req !== 1'b0) begin n_bad++; $display("FAIL mul_reset_idle: got %b want 0", hold_req); end
        $display("mul reset: hold_req=%b", hold_req);
    endtask
`else
    task automatic test_sra();
        set_nop();
        EX_ALUop = 3'b111; EX_RD = 16'h8000; EX_RS = 16'h0004; EX_RegWe = 1'b1;
        #1;
        n_cmp++; if (hold_req !== 1'b0) begin n_bad++; $display("FAIL sra_hold_req: got %b want 0", hold_req); end
        step();
        n_cmp++; if (MEM_ALUres !== 16'hF800) begin n_bad++; $display("FAIL sra_neg: got %h want f800", MEM_ALUres); end
        EX_RS = 16'h0010;
        step();
        n_cmp++; if (MEM_ALUres !== 16'h8000) begin n_bad++; $display("FAIL sra_shamt_wrap: got %h want 8000", MEM_ALUres); end
        EX_RD = 16'h4000; EX_RS = 16'h0002;
        step();
        n_cmp++; if (MEM_ALUres !== 16'h1000) begin n_bad++; $display("FAIL sra_pos: got %h want 1000", MEM_ALUres); end
        $display("sra: MEM_ALUres=%h", MEM_ALUres);
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_alu_ops();
        test_branch();
        test_hold_clear();
        test_async_reset();
`ifdef EX_MUL_EN
        test_mul();
        test_mul_abort();
        test_mul_reset();
`else
        test_sra();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
